// File: rtl/display_word_sel.sv
// Registered channel selector for the seven-segment display path: picks one of
// NCH groups of NDIG hex digits, stepped manually or rotated by a dwell timer.
module display_word_sel #(
  parameter  int NCH   = 4,
  parameter  int NDIG  = 4,
  parameter  int DWELL = 50_000_000,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*NDIG*4-1:0]  ch_digits,
  input  logic                   mode_auto,
  input  logic                   step,
  input  logic                   hold,
  output logic [NDIG*4-1:0]      hw_digits,
  output logic [SELW-1:0]        sel_out,
  output logic                   sel_chg
);

  localparam int DW = NDIG * 4;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SELW-1:0] sel_r;
  logic [SELW-1:0] sel_nx_s;
  logic [SELW-1:0] sel_inc_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nx_s;
  logic            step_q_r;
  logic            edge_s;
  logic            tc_s;
  logic            adv_s;
  logic            chg_r;
  logic [DW-1:0]   digits_s;
  logic [DW-1:0]   hw_r;
  logic [SELW-1:0] sel_out_r;

  // Next-state decision for the selection and the dwell counter
  always_comb begin
    edge_s = step & ~step_q_r;
    tc_s   = mode_auto & ~hold & (cnt_r == CW'(DWELL - 1));
    // A single-channel build never advances, so sel_chg stays low
    adv_s  = (edge_s | tc_s) & (NCH > 1);

    if (sel_r == SELW'(NCH - 1)) begin
      sel_inc_s = '0;
    end else begin
      sel_inc_s = sel_r + SELW'(1);
    end

    if (adv_s) begin
      sel_nx_s = sel_inc_s;
    end else begin
      sel_nx_s = sel_r;
    end

    // Any edge or terminal count restarts a full dwell period
    if (!mode_auto) begin
      cnt_nx_s = '0;
    end else if (edge_s | tc_s) begin
      cnt_nx_s = '0;
    end else if (hold) begin
      cnt_nx_s = cnt_r;
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end

    digits_s = ch_digits[32'(sel_r) * DW +: DW];
  end

  // Selection state, step history and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r     <= '0;
      cnt_r     <= '0;
      step_q_r  <= 1'b1;
      chg_r     <= 1'b0;
      hw_r      <= '0;
      sel_out_r <= '0;
    end else begin
      sel_r     <= sel_nx_s;
      cnt_r     <= cnt_nx_s;
      step_q_r  <= step;
      chg_r     <= adv_s;
      hw_r      <= digits_s;
      sel_out_r <= sel_r;
    end
  end

  assign hw_digits = hw_r;
  assign sel_out   = sel_out_r;
  assign sel_chg   = chg_r;

endmodule

// File: doc/display_word_sel.md
# display_word_sel

Parametrised, registered digit-group selector for the seven-segment display path. It picks one of NCH channels of NDIG hex digits (for example HI/LO, PC, ALU result) and drives them to the display driver. The channel is chosen by a debounced step input in manual mode or by a dwell timer in auto-rotate mode. It replaces fixed two-way HI/LO selection and sits between the datapath digit splitters and the seven-segment scan driver.

## Interface
- NCH, 4, number of input channels (≥1)
- NDIG, 4, hex digits per channel (≥1)
- DWELL, 50_000_000, auto-mode cycles per channel (≥1)
- SELW (localparam), NCH>1 ? $clog2(NCH) : 1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ch_digits  input  NCH*NDIG*4  channel c occupies bits [(c+1)*NDIG*4-1 : c*NDIG*4]; digit d of a channel is at [d*4+3 : d*4]
- mode_auto  input  1  1 = auto-rotate, 0 = manual
- step  input  1  already debounced level; each rising edge advances one channel
- hold  input  1  freezes the auto-rotate timer and selection; has no effect on step
- hw_digits  output  NDIG*4  registered digits of the displayed channel
- sel_out  output  SELW  index of the channel currently on hw_digits
- sel_chg  output  1  one-cycle pulse in the cycle the internal selection changes

## Operation
- State:
  - sel register, SELW bits
  - dwell counter, wide enough for DWELL-1
  - step_q, previous value of step
  - output registers hw_digits and sel_out
- Step edge: edge = step & ~step_q.
- Advance: sel_next = (sel == NCH-1) ? 0 : sel+1. With NCH=1, sel is always 0 and sel_chg never asserts.
- Manual mode (mode_auto=0):
  - The counter is held at 0.
  - An edge advances sel.
- Auto mode (mode_auto=1, hold=0):
  - The counter increments each cycle.
  - When the counter reaches DWELL-1, sel advances and the counter returns to 0.
- Auto mode with hold=1: counter and timer advance are frozen. An edge still advances sel and clears the counter.
- An edge in auto mode always clears the counter, restarting a full dwell period.
- Simultaneous edge and terminal count: sel advances exactly once and the counter goes to 0.
- Mode change:
  - Manual to auto: the counter starts from 0, giving a full DWELL before the first auto advance.
  - Auto to manual: the counter is cleared and sel is retained.
- sel_chg is registered. It is high in the cycle after the cycle in which an advance was decided, aligned with the new sel value.
- Output path, every cycle:
  - hw_digits <= channel sel of ch_digits
  - sel_out <= sel
- Reset values:
  - sel = 0, counter = 0, sel_chg = 0
  - step_q = 1, so a step held high through reset does not advance
  - hw_digits = 0, sel_out = 0
- Reset has priority over all other inputs, including in the middle of a dwell period.

## Timing
- ch_digits to hw_digits: 1 cycle latency, with no combinational path from inputs to outputs.
- Step rising edge sampled at cycle N:
  - sel changes at N+1, and sel_chg is high during N+1.
  - hw_digits and sel_out show the new channel at N+2.
- Auto mode: an advance happens every DWELL cycles, measured from reset release, from entering auto, or from the last edge.
  - DWELL=1 advances every cycle.
- sel_out and hw_digits always refer to the same channel in the same cycle.
- The first hw_digits update after rst deasserts happens one cycle after deassertion.

## Test plan
- Reset: assert rst for 3 cycles with step=1 and mode_auto=1, then release step=1 → hw_digits=0 and sel_out=0 during reset; no advance on the cycle after release; sel_out=0 for the next 4 cycles.
- Manual wrap: NCH=4, NDIG=4, ch_digits=0x3333_2222_1111_0000, five step pulses spaced 3 cycles apart → sel_out steps 1, 2, 3, 0, 1; hw_digits steps 0x1111, 0x2222, 0x3333, 0x0000, 0x1111; each value appears 2 cycles after its edge; sel_chg pulses 5 times.
- Auto rotate: DWELL=5, mode_auto=1 from reset → sel advances at 5, 10, 15 and 20 cycles after release; wraps to 0 at 20 cycles; hw_digits follows one cycle later.
- Hold: auto mode with hold=1 for 12 cycles in the middle of a dwell period, counter at 2 → sel is unchanged during hold; the next advance comes 3 cycles after hold drops. Repeat with one step edge during hold → exactly one advance, and the next auto advance is 5 cycles after hold drops.
- Simultaneous events: a step edge in the same cycle the counter reaches 4 (DWELL=5) → single advance (for example 1 to 2, not 3); the next auto advance is 5 cycles later.
- Data tracking and NCH=1: change channel 2 digits from 0x2222 to 0xABCD while sel=2 → hw_digits=0xABCD one cycle later. Build with NCH=1 and DWELL=1 in auto mode → sel_out stays 0 and sel_chg is never high.
